instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decode/control path of the single-cycle MIPS32 core.
- Owns the program counter and requests instructions from a handshaked instruction memory.
- Presents each fetched word as IR for exactly one execute cycle, then updates PC with sequential NPC or the branch target.
- Branch-taken comes from the control path's sel3 (NPC/ALU-result select).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
HALT_OPCODE, 6'b111111, IR[31:26] value that stops fetching
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, all state on rising edge
clr_PC  input  1  synchronous active-high reset
imem_req  output  1  instruction read request
imem_addr  output  32  word-aligned fetch address (= PC)
imem_rdata  input  32  instruction word, valid when imem_ready=1
imem_ready  input  1  memory accepts/returns data this cycle
sel3  input  1  branch taken for the instruction currently in IR (1 = load branch_target)
branch_target  input  32  ALU result: NPC + offset
IR  output  32  current instruction to control path
ir_valid  output  1  IR is executing this cycle; downstream qualifies reg_wr/mem_wr with it
PC  output  32  address of current instruction
NPC  output  32  PC + 4, feeds ALU input mux for branches
halted  output  1  HALT state reached
fault  output  1  misaligned branch target detected (sticky)
instr_count  output  CNT_W  retired-instruction counter

Behaviour:
- Reset: clr_PC sampled on rising edge, overrides all activity including an in-flight fetch.
- Reset values: PC=RESET_PC; IR=0; ir_valid=0; halted=0; fault=0; instr_count=0; state=FETCH.
- imem_req is combinational from state.
- State FETCH:
  - imem_req=1; imem_addr=PC; ir_valid=0.
  - imem_req held high until imem_ready=1; zero-wait memory allowed (ready in first FETCH cycle).
  - On ready: IR<=imem_rdata, state<=EXEC. Returned data is ignored when ready=0.
- State EXEC (exactly 1 cycle):
  - ir_valid=1; imem_req=0. Control path decodes IR combinationally; sel3 and branch_target are valid this cycle.
  - If IR[31:26]==HALT_OPCODE: PC unchanged; instr_count unchanged; state<=HALT.
  - Else if sel3=1 and branch_target[1:0]!=0: fault<=1; PC unchanged; state<=HALT; instructions are not counted.
  - Else: PC<=sel3 ? branch_target : NPC; instr_count<=instr_count+1 (wraps modulo 2^CNT_W); state<=FETCH.
- State HALT:
  - halted=1; imem_req=0; ir_valid=0. IR holds its last value.
  - Exit only via clr_PC.
- NPC = PC+4, computed combinationally; wraps 32'hFFFF_FFFC -> 0 without a flag.
- Latency:
  - Minimum 2 cycles per instruction (FETCH with immediate ready, then EXEC).
  - Each memory wait cycle adds 1 cycle.
- sel3 is ignored outside EXEC.
- branch_target is sampled only when sel3=1.
- Reset asserted during FETCH with ready=1 on the same edge: reset wins; IR=0.

Test Plan:
- Reset then zero-wait memory holding four add instructions at 0x0,0x4,0x8,0xC -> imem_addr sequence 0,4,8,C; ir_valid pulses every 2nd cycle; instr_count=4 after 8 cycles.
- imem_ready delayed 3 cycles on the fetch at 0x4 -> imem_req held high with addr=0x4 for 3 cycles; IR updates only on the ready cycle; a single ir_valid pulse.
- BEQZ at 0x8 with sel3=1 and branch_target=0x20 during EXEC -> next imem_addr=0x20; with sel3=0 -> next imem_addr=0xC.
- sel3=1 with branch_target=0x22 -> fault=1, halted=1 next cycle; PC stays 0x8; imem_req stays 0 thereafter.
- IR opcode 6'b111111 fetched at 0x10 -> halted=1; PC=0x10; instr_count unchanged; clr_PC pulse -> PC=0, halted=0, fetch resumes at 0.
- clr_PC asserted in the cycle imem_ready=1 -> IR=0; ir_valid=0; PC=RESET_PC; fetch restarts next cycle.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns PC, fetches over a ready handshake, presents IR
// for one execute cycle, then advances to NPC or the branch target.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             clr_PC,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_ready,
  input  logic             sel3,
  input  logic [31:0]      branch_target,
  output logic [31:0]      IR,
  output logic             ir_valid,
  output logic [31:0]      PC,
  output logic [31:0]      NPC,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;
  state_t state;

  logic is_halt, bad_target;
  assign is_halt    = (IR[31:26] == HALT_OPCODE);
  assign bad_target = sel3 && (branch_target[1:0] != 2'b00);

  assign NPC       = PC + 32'd4;
  assign imem_addr = PC;
  assign imem_req  = (state == FETCH);
  assign ir_valid  = (state == EXEC);
  assign halted    = (state == HALT);

  always_ff @(posedge clk) begin
    if (clr_PC) begin
      PC          <= RESET_PC;
      IR          <= '0;
      fault       <= 1'b0;
      instr_count <= '0;
      state       <= FETCH;
    end else begin
      case (state)
        FETCH: if (imem_ready) begin
          IR    <= imem_rdata;
          state <= EXEC;
        end
        EXEC: begin
          // Halt and misaligned-branch both freeze PC and do not retire.
          if (is_halt) begin
            state <= HALT;
          end else if (bad_target) begin
            fault <= 1'b1;
            state <= HALT;
          end else begin
            PC          <= sel3 ? branch_target : NPC;
            instr_count <= instr_count + CNT_W'(1);
            state       <= FETCH;
          end
        end
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: one task per scenario, inline checks.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        clr_PC = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready = 1'b1;
  logic        sel3 = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] IR, PC, NPC;
  logic        ir_valid, halted, fault;
  logic [31:0] instr_count;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:63];
  assign imem_rdata = mem[imem_addr[7:2]];

  instr_fetch_unit dut (
    .clk(clk), .clr_PC(clr_PC), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .sel3(sel3),
    .branch_target(branch_target), .IR(IR), .ir_valid(ir_valid), .PC(PC),
    .NPC(NPC), .halted(halted), .fault(fault), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr_PC = 1'b1; imem_ready = 1'b1; sel3 = 1'b0; branch_target = '0;
    step();
    clr_PC = 1'b0;
  endtask

  // Runs n sequential instructions with zero-wait memory and no branches.
  task automatic run_instrs(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      step();
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (PC !== 32'h0) begin fails++; $display("FAIL reset_pc got %h want 0", PC); end
    tests++; if (IR !== 32'h0) begin fails++; $display("FAIL reset_ir got %h want 0", IR); end
    tests++; if ({ir_valid, halted, fault} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {ir_valid, halted, fault}); end
    tests++; if (instr_count !== 32'h0) begin fails++; $display("FAIL reset_count got %0d want 0", instr_count); end
    tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL reset_req got %b want 1", imem_req); end
  endtask

  task automatic test_zero_wait();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tests++; if ({imem_req, ir_valid, imem_addr} !== {2'b10, 32'(i * 4)}) begin
        fails++; $display("FAIL zw_fetch%0d got req=%b v=%b addr=%h want req=1 v=0 addr=%h", i, imem_req, ir_valid, imem_addr, i * 4);
      end
      step();
      tests++; if ({imem_req, ir_valid, IR} !== {2'b01, mem[i]}) begin
        fails++; $display("FAIL zw_exec%0d got req=%b v=%b ir=%h want req=0 v=1 ir=%h", i, imem_req, ir_valid, IR, mem[i]);
      end
      step();
    end
    tests++; if (instr_count !== 32'd4) begin fails++; $display("FAIL zw_count got %0d want 4", instr_count); end
  endtask

  task automatic test_halt();
    // Continues from test_zero_wait: PC=0x10 holds the halt opcode.
    step();
    step();
    tests++; if ({halted, imem_req, ir_valid} !== 3'b100) begin fails++; $display("FAIL halt_flags got %b want 100", {halted, imem_req, ir_valid}); end
    tests++; if (PC !== 32'h10) begin fails++; $display("FAIL halt_pc got %h want 10", PC); end
    tests++; if (instr_count !== 32'd4) begin fails++; $display("FAIL halt_count got %0d want 4", instr_count); end
    tests++; if (IR !== mem[4]) begin fails++; $display("FAIL halt_ir got %h want %h", IR, mem[4]); end
    step();
    step();
    tests++; if ({halted, imem_req} !== 2'b10) begin fails++; $display("FAIL halt_stay got %b want 10", {halted, imem_req}); end
    clr_PC = 1'b1;
    step();
    clr_PC = 1'b0;
    tests++; if ({PC, halted, imem_req, instr_count} !== {32'h0, 2'b01, 32'h0}) begin
      fails++; $display("FAIL halt_clear got pc=%h h=%b req=%b cnt=%0d want pc=0 h=0 req=1 cnt=0", PC, halted, imem_req, instr_count);
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    run_instrs(1);
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++; if ({imem_req, ir_valid, imem_addr, IR} !== {2'b10, 32'h4, mem[0]}) begin
        fails++; $display("FAIL wait%0d got req=%b v=%b addr=%h ir=%h want req=1 v=0 addr=4 ir=%h", i, imem_req, ir_valid, imem_addr, IR, mem[0]);
      end
      step();
    end
    imem_ready = 1'b1;
    step();
    tests++; if ({ir_valid, IR} !== {1'b1, mem[1]}) begin fails++; $display("FAIL wait_exec got v=%b ir=%h want v=1 ir=%h", ir_valid, IR, mem[1]); end
    step();
    tests++; if ({ir_valid, imem_addr, instr_count} !== {1'b0, 32'h8, 32'd2}) begin
      fails++; $display("FAIL wait_after got v=%b addr=%h cnt=%0d want v=0 addr=8 cnt=2", ir_valid, imem_addr, instr_count);
    end
  endtask

  task automatic test_branch();
    do_reset();
    run_instrs(2);
    step();
    sel3 = 1'b1; branch_target = 32'h20;
    tests++; if (NPC !== 32'hC) begin fails++; $display("FAIL br_npc got %h want c", NPC); end
    step();
    sel3 = 1'b0;
    tests++; if ({imem_addr, instr_count} !== {32'h20, 32'd3}) begin fails++; $display("FAIL br_taken got addr=%h cnt=%0d want addr=20 cnt=3", imem_addr, instr_count); end
    // Not taken; a bad target during FETCH must be ignored.
    do_reset();
    run_instrs(2);
    sel3 = 1'b1; branch_target = 32'h22;
    step();
    sel3 = 1'b0;
    step();
    tests++; if ({imem_addr, fault, halted} !== {32'hC, 2'b00}) begin fails++; $display("FAIL br_not_taken got addr=%h f=%b h=%b want addr=c f=0 h=0", imem_addr, fault, halted); end
    // Branch to top word: NPC wraps to 0.
    step();
    sel3 = 1'b1; branch_target = 32'hFFFF_FFFC;
    step();
    sel3 = 1'b0;
    tests++; if ({imem_addr, NPC} !== {32'hFFFF_FFFC, 32'h0}) begin fails++; $display("FAIL wrap_npc got addr=%h npc=%h want fffffffc/0", imem_addr, NPC); end
    step();
    step();
    tests++; if ({imem_addr, instr_count} !== {32'h0, 32'd5}) begin fails++; $display("FAIL wrap_pc got addr=%h cnt=%0d want 0/5", imem_addr, instr_count); end
  endtask

  task automatic test_fault();
    do_reset();
    run_instrs(2);
    step();
    sel3 = 1'b1; branch_target = 32'h22;
    step();
    sel3 = 1'b0; branch_target = '0;
    tests++; if ({fault, halted, imem_req} !== 3'b110) begin fails++; $display("FAIL fault_flags got %b want 110", {fault, halted, imem_req}); end
    tests++; if ({PC, instr_count} !== {32'h8, 32'd2}) begin fails++; $display("FAIL fault_pc got pc=%h cnt=%0d want 8/2", PC, instr_count); end
    step();
    step();
    tests++; if ({fault, halted, imem_req, ir_valid} !== 4'b1100) begin fails++; $display("FAIL fault_sticky got %b want 1100", {fault, halted, imem_req, ir_valid}); end
  endtask

  task automatic test_reset_vs_ready();
    do_reset();
    run_instrs(2);
    imem_ready = 1'b1; clr_PC = 1'b1;
    step();
    clr_PC = 1'b0;
    tests++; if ({IR, ir_valid, PC, imem_req} !== {32'h0, 1'b0, 32'h0, 1'b1}) begin
      fails++; $display("FAIL rst_ready got ir=%h v=%b pc=%h req=%b want 0/0/0/1", IR, ir_valid, PC, imem_req);
    end
    step();
    tests++; if ({ir_valid, IR} !== {1'b1, mem[0]}) begin fails++; $display("FAIL rst_restart got v=%b ir=%h want 1/%h", ir_valid, IR, mem[0]); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {6'b0, 5'd1, 5'd2, 5'(i), 5'd0, 6'h20};
    mem[2] = {6'b000100, 5'd3, 5'd0, 16'h0005};
    mem[4] = {6'b111111, 26'h0};
    test_reset();
    test_zero_wait();
    test_halt();
    test_wait_states();
    test_branch();
    test_fault();
    test_reset_vs_ready();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
